// File: rtl/stopwatch_buttons.sv
// Pushbutton conditioning for the stopwatch: per-button synchronizer, debouncer and
// press detector, feeding run/clear/hold control. Optional lap channel: STOPWATCH_LAP_EN.

module stopwatch_buttons_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic                   stable_d;
    logic                   prev_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronized input agrees with the stable level restarts the count,
    // so only an unbroken run of DEBOUNCE_CYCLES disagreeing cycles changes the level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_s != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = stable_q & ~prev_q;
endmodule

module stopwatch_buttons #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic btn_lap,
`endif
    output logic run,
    output logic clear_pulse,
    output logic hold
);
    localparam int CH_SS  = 0;
    localparam int CH_CLR = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int CH_LAP = 2;
    localparam int NUM_CH = 3;
`else
    localparam int NUM_CH = 2;
`endif

    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] press;

    assign btn_raw[CH_SS]  = btn_start_stop;
    assign btn_raw[CH_CLR] = btn_clear;
`ifdef STOPWATCH_LAP_EN
    assign btn_raw[CH_LAP] = btn_lap;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            stopwatch_buttons_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_ch (
                .clk    (clk),
                .reset  (reset),
                .btn_i  (btn_raw[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

    logic run_q;
    logic run_d;
    logic clear_q;
    logic clear_d;

`ifdef STOPWATCH_LAP_EN
    logic hold_q;
    logic hold_d;
`endif

    // Clear overrides everything; start/stop and lap may act together, and the lap
    // decision looks at run as it was before this cycle's toggle.
    always_comb begin
        run_d   = run_q;
        clear_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
        hold_d  = hold_q;
`endif
        if (press[CH_CLR]) begin
            run_d   = 1'b0;
            clear_d = 1'b1;
`ifdef STOPWATCH_LAP_EN
            hold_d  = 1'b0;
`endif
        end else begin
            if (press[CH_SS]) begin
                run_d = ~run_q;
            end
`ifdef STOPWATCH_LAP_EN
            if (press[CH_LAP]) begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (run_q) begin
                    hold_d = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            clear_q <= clear_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;
`else
    assign hold = 1'b0;
`endif

    assign run         = run_q;
    assign clear_pulse = clear_q;
endmodule

// File: tb/tb_stopwatch_buttons.sv
// Directed bench for stopwatch_buttons (D=4, N=2, press latency 7 edges); expectations are
// queued with their due cycle when stimulus is applied and checked when that cycle arrives.

module tb_stopwatch_buttons;
    localparam int D = 4;
    localparam int N = 2;
`ifdef STOPWATCH_LAP_EN
    localparam logic H_LAP = 1'b1;
`else
    localparam logic H_LAP = 1'b0;
`endif

    logic clk;
    logic reset;
    logic btn_start_stop;
    logic btn_clear;
`ifdef STOPWATCH_LAP_EN
    logic btn_lap;
`endif
    logic run;
    logic clear_pulse;
    logic hold;

    stopwatch_buttons #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap       (btn_lap),
`endif
        .run           (run),
        .clear_pulse   (clear_pulse),
        .hold          (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        logic  r;
        logic  h;
        logic  c;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic expect_at(input int rel, input string tag, input logic r, input logic h, input logic c);
        exp_t e;
        e.cyc = cyc + rel;
        e.tag = tag;
        e.r   = r;
        e.h   = h;
        e.c   = c;
        sb.push_back(e);
    endtask

    // Each tick samples 1 time unit after the rising edge, then retires due expectations.
    task automatic advance(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                assert ({run, hold, clear_pulse} === {e.r, e.h, e.c}) else begin
                    bad++;
                    $error("FAIL %s cyc=%0d due=%0d got run/hold/clr=%b%b%b want %b%b%b",
                           e.tag, cyc, e.cyc, run, hold, clear_pulse, e.r, e.h, e.c);
                end
                $display("check %-14s cyc=%0d run/hold/clr=%b%b%b", e.tag, cyc, run, hold, clear_pulse);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        btn_start_stop = 1'b1;
        btn_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap        = 1'b1;
`endif
        // Reset with buttons held, then held start/stop is seen as a fresh press.
        expect_at(1, "rst_e1", 0, 0, 0);
        expect_at(3, "rst_e3", 0, 0, 0);
        advance(3);
        reset = 1'b1;
        expect_at(6, "rst_rel_e6", 0, 0, 0);
        expect_at(7, "rst_rel_e7", 1, 0, 0);
        expect_at(9, "rst_rel_e9", 1, 0, 0);
        advance(9);

        btn_start_stop = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap        = 1'b0;
`endif
        expect_at(10, "release", 1, 0, 0);
        advance(10);

        // Clear while running: one-cycle pulse.
        btn_clear = 1'b1;
        expect_at(6, "clr_e6", 1, 0, 0);
        expect_at(7, "clr_e7", 0, 0, 1);
        expect_at(8, "clr_e8", 0, 0, 0);
        advance(10);
        btn_clear = 1'b0;
        expect_at(10, "clr_release", 0, 0, 0);
        advance(10);

        // Start/stop 10 high, 10 low, 10 high.
        btn_start_stop = 1'b1;
        expect_at(6, "ss1_e6", 0, 0, 0);
        expect_at(7, "ss1_e7", 1, 0, 0);
        advance(10);
        btn_start_stop = 1'b0;
        expect_at(10, "ss1_low", 1, 0, 0);
        advance(10);
        btn_start_stop = 1'b1;
        expect_at(6, "ss2_e6", 1, 0, 0);
        expect_at(7, "ss2_e7", 0, 0, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);

        // Bounce: 3 high, 1 low, 3 high must be rejected.
        expect_at(2, "bounce_a", 0, 0, 0);
        btn_start_stop = 1'b1;
        advance(3);
        btn_start_stop = 1'b0;
        advance(1);
        btn_start_stop = 1'b1;
        advance(3);
        btn_start_stop = 1'b0;
        expect_at(4, "bounce_b", 0, 0, 0);
        expect_at(12, "bounce_c", 0, 0, 0);
        advance(12);
        // A full press afterwards must still need the whole latency.
        btn_start_stop = 1'b1;
        expect_at(6, "post_bnc_e6", 0, 0, 0);
        expect_at(7, "post_bnc_e7", 1, 0, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);

`ifdef STOPWATCH_LAP_EN
        btn_lap = 1'b1;
        expect_at(6, "lap1_e6", 1, 0, 0);
        expect_at(7, "lap1_e7", 1, 1, 0);
        advance(10);
        btn_lap = 1'b0;
        advance(10);
        btn_lap = 1'b1;
        expect_at(6, "lap2_e6", 1, 1, 0);
        expect_at(7, "lap2_e7", 1, 0, 0);
        advance(10);
        btn_lap = 1'b0;
        advance(10);
        btn_start_stop = 1'b1;
        expect_at(7, "stop", 0, 0, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);
        btn_lap = 1'b1;
        expect_at(7, "lap_idle_e7", 0, 0, 0);
        expect_at(9, "lap_idle_e9", 0, 0, 0);
        advance(10);
        btn_lap = 1'b0;
        advance(10);
        btn_start_stop = 1'b1;
        expect_at(7, "restart", 1, 0, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);
        btn_lap = 1'b1;
        expect_at(7, "lap3", 1, 1, 0);
        advance(10);
        btn_lap = 1'b0;
        advance(10);
        // Stopping keeps hold; starting again keeps it too.
        btn_start_stop = 1'b1;
        expect_at(7, "stop_hold", 0, 1, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);
        btn_start_stop = 1'b1;
        expect_at(7, "start_hold", 1, 1, 0);
        advance(10);
        btn_start_stop = 1'b0;
        advance(10);
`endif

        // Clear and start/stop together: clear wins.
        btn_clear      = 1'b1;
        btn_start_stop = 1'b1;
        expect_at(6, "sim_e6", 1, H_LAP, 0);
        expect_at(7, "sim_e7", 0, 0, 1);
        expect_at(8, "sim_e8", 0, 0, 0);
        advance(10);
        btn_clear      = 1'b0;
        btn_start_stop = 1'b0;
        expect_at(10, "sim_release", 0, 0, 0);
        advance(10);

        // Reset after two debounce counts; button stays high.
        btn_start_stop = 1'b1;
        advance(4);
        reset = 1'b0;
        expect_at(1, "midrst", 0, 0, 0);
        advance(1);
        reset = 1'b1;
        expect_at(3, "midrst_e3", 0, 0, 0);
        expect_at(6, "midrst_e6", 0, 0, 0);
        expect_at(7, "midrst_e7", 1, 0, 0);
        advance(8);
        btn_start_stop = 1'b0;
        advance(4);

        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
